// File: rtl/id_ex_pipe_pkg.sv
// Shared types and widths for the ID/EX pipeline register slice.
package id_ex_pipe_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT4_W   = 4;
    localparam int unsigned ALUOP_W    = 2;
    localparam int unsigned BCNT_W     = 16;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluop_e;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]       read_data1;
        logic [XLEN-1:0]       read_data2;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [FUNCT4_W-1:0]   funct4;
    } payload_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
        return (&v) ? v : BCNT_W'(v + BCNT_W'(1));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register the instruction in ID reads.
module hazard_detect
    import id_ex_pipe_pkg::*;
(
    input  logic                  i_mem_read,
    input  logic                  i_valid,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hazard_c
);

    logic w_rd_nonzero;
    logic w_match;

    // x0 is hardwired, so a load targeting it can never create a dependency.
    assign w_rd_nonzero = |i_rd;
    assign w_match      = (i_rd == i_rs1) || (i_rd == i_rs2);
    assign o_hazard_c   = i_mem_read && i_valid && w_rd_nonzero && w_match;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush/stall handling, load-use bubble insertion and a bubble counter.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [XLEN-1:0]       ReadData1_in,
    input  logic [XLEN-1:0]       ReadData2_in,
    input  logic [XLEN-1:0]       Imm_in,
    input  logic [XLEN-1:0]       PC_in,
    input  logic [REG_ADDR_W-1:0] RS1_in,
    input  logic [REG_ADDR_W-1:0] RS2_in,
    input  logic [REG_ADDR_W-1:0] RD_in,
    input  logic [FUNCT4_W-1:0]   Funct4_in,
    input  logic                  RegWrite_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  MemtoReg_in,
    input  logic                  Branch_in,
    input  logic                  ALUSrc_in,
    input  logic [ALUOP_W-1:0]    ALUOp_in,
    output logic [XLEN-1:0]       ReadData1_out,
    output logic [XLEN-1:0]       ReadData2_out,
    output logic [XLEN-1:0]       Imm_out,
    output logic [XLEN-1:0]       PC_out,
    output logic [REG_ADDR_W-1:0] RS1_out,
    output logic [REG_ADDR_W-1:0] RS2_out,
    output logic [REG_ADDR_W-1:0] RD_out,
    output logic [FUNCT4_W-1:0]   Funct4_out,
    output logic                  RegWrite_out,
    output logic                  MemRead_out,
    output logic                  MemWrite_out,
    output logic                  MemtoReg_out,
    output logic                  Branch_out,
    output logic                  ALUSrc_out,
    output logic [ALUOP_W-1:0]    ALUOp_out,
    output logic                  Valid_out,
    output logic                  HazardStall,
    output logic [BCNT_W-1:0]     BubbleCount
);

    payload_t          r_payload;
    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [BCNT_W-1:0] r_bubble_cnt;

    payload_t w_payload_in;
    ctrl_t    w_ctrl_in;
    logic     w_hazard;
    logic     w_advance;
    logic     w_load_bubble;

    assign w_payload_in = '{read_data1: ReadData1_in, read_data2: ReadData2_in,
                            imm: Imm_in, pc: PC_in, rs1: RS1_in, rs2: RS2_in,
                            rd: RD_in, funct4: Funct4_in};
    assign w_ctrl_in    = '{reg_write: RegWrite_in, mem_read: MemRead_in,
                            mem_write: MemWrite_in, mem_to_reg: MemtoReg_in,
                            branch: Branch_in, alu_src: ALUSrc_in, alu_op: ALUOp_in};

    hazard_detect u_hazard_detect (
        .i_mem_read (r_ctrl.mem_read),
        .i_valid    (r_valid),
        .i_rd       (r_payload.rd),
        .i_rs1      (RS1_in),
        .i_rs2      (RS2_in),
        .o_hazard_c (w_hazard)
    );

    // Flush beats Stall; a hazard only acts when the stage is not held.
    assign w_advance     = Flush || !Stall;
    assign w_load_bubble = Flush || w_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_payload    <= '0;
            r_ctrl       <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (w_advance) begin
            if (w_load_bubble) begin
                r_payload    <= '0;
                r_ctrl       <= '0;
                r_valid      <= 1'b0;
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_payload    <= w_payload_in;
                r_ctrl       <= w_ctrl_in;
                r_valid      <= 1'b1;
            end
        end
    end

    assign ReadData1_out = r_payload.read_data1;
    assign ReadData2_out = r_payload.read_data2;
    assign Imm_out       = r_payload.imm;
    assign PC_out        = r_payload.pc;
    assign RS1_out       = r_payload.rs1;
    assign RS2_out       = r_payload.rs2;
    assign RD_out        = r_payload.rd;
    assign Funct4_out    = r_payload.funct4;
    assign RegWrite_out  = r_ctrl.reg_write;
    assign MemRead_out   = r_ctrl.mem_read;
    assign MemWrite_out  = r_ctrl.mem_write;
    assign MemtoReg_out  = r_ctrl.mem_to_reg;
    assign Branch_out    = r_ctrl.branch;
    assign ALUSrc_out    = r_ctrl.alu_src;
    assign ALUOp_out     = r_ctrl.alu_op;
    assign Valid_out     = r_valid;
    assign BubbleCount   = r_bubble_cnt;
    assign HazardStall   = w_hazard;

endmodule
